// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
//
// Groups every signal that runs between the register-file write arbiter and
// its two requesters and the register file itself.
//
// Signals:
//   wb_en / wb_rd / wb_data   pipeline writeback request (no handshake)
//   io_req / io_rd / io_data  I/O write request, held until io_ack
//   io_ack                    one-cycle pulse, I/O write issued this cycle
//   stall                     pipeline freeze, upstream holds writeback
//   rf_ren / rf_rd / rf_data  register file write port
//   rf_src                    source of the current write (0 = wb, 1 = I/O)
//
// Modports:
//   slave  - the arbiter side (consumes requests, drives the write port)
//   master - the requester / environment side
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              wb_en;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              io_req;
  logic [ADDR_W-1:0] io_rd;
  logic [DATA_W-1:0] io_data;
  logic              io_ack;
  logic              stall;
  logic              rf_ren;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic              rf_src;

  modport slave (
    input  wb_en, wb_rd, wb_data,
    input  io_req, io_rd, io_data,
    output io_ack, stall,
    output rf_ren, rf_rd, rf_data, rf_src
  );

  modport master (
    output wb_en, wb_rd, wb_data,
    output io_req, io_rd, io_data,
    input  io_ack, stall,
    input  rf_ren, rf_rd, rf_data, rf_src
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the register file's single write port between the pipeline
// writeback path and an I/O requester (e.g. the controller that deposits
// player input into registers). Writeback has priority; the I/O requester is
// served through a req/ack handshake. An aging counter bounds I/O starvation:
// after MAX_WAIT consecutive writeback wins over a pending I/O request the
// pipeline is frozen for exactly one cycle so the I/O write can go through.
// All outputs are registered, so a granted write reaches the register file
// one cycle after it is sampled.
//
// Ports:
//   clock  - single clock, rising edge
//   reset  - synchronous, active-high
//   bus    - regfile_write_arbiter_if.slave (requests in, write port out)
//
// Parameters:
//   DATA_W   - register data width
//   ADDR_W   - register address width
//   MAX_WAIT - writeback wins tolerated over a pending I/O request (>= 1)
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  regfile_write_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t            state_q,    state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              rf_ren_q,   rf_ren_d;
  logic [ADDR_W-1:0] rf_rd_q,    rf_rd_d;
  logic [DATA_W-1:0] rf_data_q,  rf_data_d;
  logic              rf_src_q,   rf_src_d;
  logic              io_ack_q,   io_ack_d;
  logic              stall_q,    stall_d;

  // Next-state decision, evaluated in priority order: a pending forced
  // stall first, then the ack cycle (which must not re-grant the request
  // still held high by the requester), then writeback, then I/O.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    rf_ren_d   = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_data_d  = rf_data_q;
    rf_src_d   = rf_src_q;
    io_ack_d   = 1'b0;
    stall_d    = 1'b0;

    if (state_q == STALL) begin
      // The pipeline is frozen this cycle; its writeback is re-presented
      // next cycle, so wb_en can be ignored here.
      rf_ren_d   = 1'b1;
      rf_rd_d    = bus.io_rd;
      rf_data_d  = bus.io_data;
      rf_src_d   = 1'b1;
      io_ack_d   = 1'b1;
      wait_cnt_d = '0;
      state_d    = RUN;
    end else if (io_ack_q) begin
      if (bus.wb_en) begin
        rf_ren_d  = 1'b1;
        rf_rd_d   = bus.wb_rd;
        rf_data_d = bus.wb_data;
        rf_src_d  = 1'b0;
      end
    end else if (bus.wb_en) begin
      rf_ren_d  = 1'b1;
      rf_rd_d   = bus.wb_rd;
      rf_data_d = bus.wb_data;
      rf_src_d  = 1'b0;
      if (bus.io_req) begin
        // This win is the last one tolerated: freeze the pipeline for the
        // next cycle so the I/O write is issued from the STALL state.
        if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          stall_d = 1'b1;
          state_d = STALL;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
    end else if (bus.io_req) begin
      rf_ren_d   = 1'b1;
      rf_rd_d    = bus.io_rd;
      rf_data_d  = bus.io_data;
      rf_src_d   = 1'b1;
      io_ack_d   = 1'b1;
      wait_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      rf_ren_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_data_q  <= '0;
      rf_src_q   <= 1'b0;
      io_ack_q   <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rf_ren_q   <= rf_ren_d;
      rf_rd_q    <= rf_rd_d;
      rf_data_q  <= rf_data_d;
      rf_src_q   <= rf_src_d;
      io_ack_q   <= io_ack_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.rf_ren  = rf_ren_q;
  assign bus.rf_rd   = rf_rd_q;
  assign bus.rf_data = rf_data_q;
  assign bus.rf_src  = rf_src_q;
  assign bus.io_ack  = io_ack_q;
  assign bus.stall   = stall_q;

endmodule
